axi_lite_mem_slave: RTL



---
 rtl/axi_lite_mem_slave.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite word RAM with byte strobes, programmable wait states and DECERR/SLVERR responses.
// Read and write channels run independent FSMs; every output is driven straight from a flop.
module axi_lite_mem_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int RD_WAIT    = 0,
  parameter int WR_WAIT    = 0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ARvalid,
  output logic        ARready,
  input  logic [31:0] ARdata,
  input  logic [2:0]  arprot,
  output logic        Rvalid,
  input  logic        Rready,
  output logic [31:0] Rdata,
  output logic [1:0]  Rresp,
  input  logic        AWvalid,
  output logic        AWready,
  input  logic [31:0] AWdata,
  input  logic [2:0]  awprot,
  input  logic        Wvalid,
  output logic        Wready,
  input  logic [31:0] Wdata,
  input  logic [3:0]  Wstrb,
  output logic        Bvalid,
  input  logic        Bready,
  output logic [1:0]  Bresp
);

  // state     | meaning
  // R_IDLE    | ARready high, waiting for an address
  // R_WAIT    | address latched, RD_WAIT extra cycles then array sample
  // R_RESP    | Rvalid high, holding Rdata/Rresp until Rready
  // W_COLLECT | accepting AW and W independently until both are held
  // W_WAIT    | both held, WR_WAIT extra cycles then commit
  // W_RESP    | Bvalid high, holding Bresp until Bready

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  localparam logic [1:0] W_COLLECT = 2'd0;
  localparam logic [1:0] W_WAIT    = 2'd1;
  localparam logic [1:0] W_RESP    = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
  localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

  logic [31:0] mem [DEPTH];

  logic [1:0]  r_state_q, r_state_d;
  logic [3:0]  r_cnt_q, r_cnt_d;
  logic [31:2] r_addr_q, r_addr_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic [1:0]  w_state_q, w_state_d;
  logic [3:0]  w_cnt_q, w_cnt_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [31:2] aw_addr_q, aw_addr_d;
  logic        aw_instr_q, aw_instr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;

  logic                  mem_we;
  logic                  aw_hs, w_hs;
  logic                  r_oor, w_oor;
  logic [ADDR_WIDTH-3:0] r_idx, w_idx;
  logic                  unused_inputs;

  assign r_idx = r_addr_q[ADDR_WIDTH-1:2];
  assign w_idx = aw_addr_q[ADDR_WIDTH-1:2];
  assign r_oor = |r_addr_q[31:ADDR_WIDTH];
  assign w_oor = |aw_addr_q[31:ADDR_WIDTH];
  assign aw_hs = AWvalid && awready_q;
  assign w_hs  = Wvalid && wready_q;

  // Sub-word address bits and unused protection bits are deliberately ignored.
  assign unused_inputs = ^{arprot, awprot[1:0], ARdata[1:0], AWdata[1:0]};

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_addr_d  = r_addr_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ARvalid && arready_q) begin
          r_addr_d  = ARdata[31:2];
          r_cnt_d   = RD_CNT;
          arready_d = 1'b0;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt_q != 4'd0) begin
          r_cnt_d = r_cnt_q - 4'd1;
        end else begin
          rvalid_d  = 1'b1;
          r_state_d = R_RESP;
          if (r_oor) begin
            rdata_d = 32'd0;
            rresp_d = RESP_DECERR;
          end else begin
            rdata_d = mem[r_idx];
            rresp_d = RESP_OKAY;
          end
        end
      end
      R_RESP: begin
        if (Rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d  = w_state_q;
    w_cnt_d    = w_cnt_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_addr_d  = aw_addr_q;
    aw_instr_d = aw_instr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;
    case (w_state_q)
      W_COLLECT: begin
        if (aw_hs) begin
          aw_addr_d  = AWdata[31:2];
          aw_instr_d = awprot[2];
          aw_held_d  = 1'b1;
        end
        if (w_hs) begin
          wdata_d  = Wdata;
          wstrb_d  = Wstrb;
          w_held_d = 1'b1;
        end
        if (aw_held_d && w_held_d) begin
          w_cnt_d   = WR_CNT;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          w_state_d = W_WAIT;
        end else begin
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      W_WAIT: begin
        if (w_cnt_q != 4'd0) begin
          w_cnt_d = w_cnt_q - 4'd1;
        end else begin
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
          if (w_oor) begin
            bresp_d = RESP_DECERR;
          end else if (aw_instr_q) begin
            bresp_d = RESP_SLVERR;
          end else begin
            bresp_d = RESP_OKAY;
            mem_we  = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (Bready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_COLLECT;
        end
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state_q  <= R_IDLE;
      r_cnt_q    <= 4'd0;
      r_addr_q   <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
      rresp_q    <= 2'b00;
      w_state_q  <= W_COLLECT;
      w_cnt_q    <= 4'd0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      aw_instr_q <= 1'b0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
    end else begin
      r_state_q  <= r_state_d;
      r_cnt_q    <= r_cnt_d;
      r_addr_q   <= r_addr_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      w_state_q  <= w_state_d;
      w_cnt_q    <= w_cnt_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_addr_q  <= aw_addr_d;
      aw_instr_q <= aw_instr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // Array has no reset; a commit on a reset edge is dropped so aborted writes never land.
  always_ff @(posedge clock) begin
    if (resetn && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[w_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign ARready = arready_q;
  assign Rvalid  = rvalid_q;
  assign Rdata   = rdata_q;
  assign Rresp   = rresp_q;
  assign AWready = awready_q;
  assign Wready  = wready_q;
  assign Bvalid  = bvalid_q;
  assign Bresp   = bresp_q;

endmodule
